hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard controller that produces the stall and bubble controls consumed by the PC, IF_ID and ID_EX pipeline registers. It keeps a shadow scoreboard of the destination registers in flight in EX, MEM and WB, mirroring the ID_EX/EX_MEM/MEM_WB contents. From that scoreboard it detects read-after-write hazards for the instruction in ID, and it applies branch-redirect flushes signalled from EX. It also keeps saturating performance counters for stall and flush cycles.

## Interface
- REG_W, 5: register index width (`WIDTH_REGMARK`)
- CNT_W, 32: performance counter width
- clk  in  1: pipeline clock
- rst_n  in  1: asynchronous active-low reset
- id_rs1, id_rs2  in  REG_W: source register indices of the instruction in ID
- id_rs1_used, id_rs2_used  in  1: source is actually read
- id_RegWr  in  REG_W: destination of the instruction in ID
- id_RegWe  in  1: instruction in ID writes the register file
- id_is_load  in  1: instruction in ID takes its writeback from DRAM (load)
- ex_redirect  in  1: branch/jump resolved taken in EX this cycle
- stop_PC  out  1: hold PC
- stop_IF  out  1: hold IF_ID
- flush_IF  out  1: clear IF_ID to a bubble
- stop_ID  out  1: load a bubble into ID_EX (zero all fields)
- stall_cnt  out  CNT_W: cycles with a hazard stall
- flush_cnt  out  CNT_W: cycles with a redirect flush

## Operation
- Scoreboard: three slots EX, MEM and WB. Each slot holds {valid, rd, is_load}.
- Every cycle:
  - WB takes MEM.
  - MEM takes EX.
  - EX takes {id_RegWe && id_RegWr!=0, id_RegWr, id_is_load} when stop_ID=0, and the empty slot otherwise.
- Match(slot) is true when:
  - slot.valid, and
  - slot.rd equals id_rs1 with id_rs1_used, or slot.rd equals id_rs2 with id_rs2_used.
  - Register x0 never matches.
- Hazard is computed combinationally from the current inputs and the scoreboard.
- Outputs are combinational. Priority, highest first:
  - ex_redirect=1: flush_IF=1, stop_ID=1, stop_PC=0, stop_IF=0. The PC loads the target and the instruction in ID is killed. A pending hazard is ignored.
  - hazard=1: stop_PC=1, stop_IF=1, stop_ID=1, flush_IF=0.
  - Otherwise all outputs are 0.
- Counters:
  - stall_cnt increments on a hazard-stall cycle.
  - flush_cnt increments on an ex_redirect cycle.
  - Both saturate at all-ones and never wrap.
- Reset: all slots invalid, both counters 0. The outputs follow from the inputs over the empty scoreboard, so they are 0 unless ex_redirect=1.

## Timing
- Hazard response has zero latency: stop_* asserts in the same cycle the instruction reaches ID. It takes effect at the next posedge.
- Without forwarding, a dependent instruction directly behind a writer stalls 3 cycles. It issues once the writer has left WB.
  - The register file writes at the posedge ending WB, and ID reads combinationally, so a WB match stalls.
- With forwarding, load-use stalls exactly 1 cycle and ALU-use stalls 0 cycles.
- Simultaneous ex_redirect and hazard: redirect wins, counted in flush_cnt only.
- A stall cycle inserts an empty EX slot. The stalled instruction is re-evaluated in the next cycle against the advanced scoreboard.
- Reset asserted mid-stall: outputs return to 0 immediately, unless ex_redirect=1. Slots are cleared asynchronously, with no partial state kept.

## Configuration
- `HAZARD_FORWARD_EN` defined:
  - hazard = Match(EX) && EX.is_load.
  - MEM and WB slots are still tracked, but do not stall.
- `HAZARD_FORWARD_EN` undefined:
  - hazard = Match(EX) || Match(MEM) || Match(WB).
  - is_load is unused.

## Structure
- Shared package/param file holds `WIDTH_REGMARK` and the scoreboard slot struct/field widths.
- One natural sub-module, `hazard_slot_match`:
  - inputs: slot fields, rs1/rs2 and the used flags
  - output: match
  - instantiated three times.

## Test plan
- Without forwarding:
  - Stimulus: `addi x5,…` then `add x6,x5,x1` with rs1=5 used.
  - Required response: stop_ID=1 for 3 consecutive cycles, then 0; stall_cnt=3.
- With `HAZARD_FORWARD_EN`:
  - Stimulus: `lw x7` then `add x8,x7,x7`.
  - Required response: exactly 1 stall cycle; stall_cnt=1.
- With `HAZARD_FORWARD_EN`:
  - Stimulus: ALU writes x7, then a reader of x7.
  - Required response: 0 stall cycles.
- x0 destination:
  - Stimulus: id_RegWr=0 with id_RegWe=1, followed by a reader of x0.
  - Required response: no stall, in either configuration.
- Redirect during hazard:
  - Stimulus: ex_redirect=1 in a cycle where the hazard is also true.
  - Required response: flush_IF=1, stop_ID=1, stop_PC=0; flush_cnt+1, stall_cnt unchanged.
- Reset mid-stall:
  - Stimulus: rst_n=0 during the 2nd stall cycle, then release.
  - Required response: outputs 0, counters 0, scoreboard empty; the reader issues without stall.
  - Counter saturation: preload stall_cnt to all-ones via a forced stall run; it stays at all-ones.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared widths and scoreboard slot type for the hazard controller
package hazard_ctrl_pkg;

    localparam int WIDTH_REGMARK = 5;
    localparam int REG_W         = WIDTH_REGMARK;

    typedef logic [REG_W-1:0] reg_idx_t;

    typedef struct packed {
        logic     valid;
        reg_idx_t rd;
        logic     is_load;
    } sb_slot_t;

    localparam sb_slot_t SLOT_EMPTY = '{valid: 1'b0, rd: '0, is_load: 1'b0};

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - ID-stage request and pipeline-control bundle for hazard_ctrl
interface hazard_ctrl_if
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) ();

    reg_idx_t         id_rs1;
    reg_idx_t         id_rs2;
    logic             id_rs1_used;
    logic             id_rs2_used;
    reg_idx_t         id_RegWr;
    logic             id_RegWe;
    logic             id_is_load;
    logic             ex_redirect;
    logic             stop_PC;
    logic             stop_IF;
    logic             flush_IF;
    logic             stop_ID;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        output id_RegWr, id_RegWe, id_is_load, ex_redirect,
        input  stop_PC, stop_IF, flush_IF, stop_ID, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        input  id_RegWr, id_RegWe, id_is_load, ex_redirect,
        output stop_PC, stop_IF, flush_IF, stop_ID, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_slot_match.sv
// rtl/hazard_slot_match.sv - compares one scoreboard slot against the ID source registers
module hazard_slot_match
    import hazard_ctrl_pkg::*;
(
    input  logic     valid_i,
    input  reg_idx_t rd_i,
    input  reg_idx_t rs1_i,
    input  reg_idx_t rs2_i,
    input  logic     rs1_used_i,
    input  logic     rs2_used_i,
    output logic     match_o
);

    // x0 is hardwired to zero, so a write to it can never create a dependency
    assign match_o = valid_i && (rd_i != '0) &&
                     (((rd_i == rs1_i) && rs1_used_i) || ((rd_i == rs2_i) && rs2_used_i));

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - RAW stall / redirect flush controller with shadow EX/MEM/WB scoreboard
// HAZARD_FORWARD_EN: when defined only a load in EX stalls; otherwise any in-flight writer stalls.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    hazard_ctrl_if.slave  hif
);

    sb_slot_t         ex_q, mem_q, wb_q;
    sb_slot_t         ex_d;
    logic [2:0]       match;
    logic             hazard;
    logic             stall_evt;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             unused_wb_load;

    hazard_slot_match u_match_ex (
        .valid_i    (ex_q.valid),
        .rd_i       (ex_q.rd),
        .rs1_i      (hif.id_rs1),
        .rs2_i      (hif.id_rs2),
        .rs1_used_i (hif.id_rs1_used),
        .rs2_used_i (hif.id_rs2_used),
        .match_o    (match[0])
    );

    hazard_slot_match u_match_mem (
        .valid_i    (mem_q.valid),
        .rd_i       (mem_q.rd),
        .rs1_i      (hif.id_rs1),
        .rs2_i      (hif.id_rs2),
        .rs1_used_i (hif.id_rs1_used),
        .rs2_used_i (hif.id_rs2_used),
        .match_o    (match[1])
    );

    hazard_slot_match u_match_wb (
        .valid_i    (wb_q.valid),
        .rd_i       (wb_q.rd),
        .rs1_i      (hif.id_rs1),
        .rs2_i      (hif.id_rs2),
        .rs1_used_i (hif.id_rs1_used),
        .rs2_used_i (hif.id_rs2_used),
        .match_o    (match[2])
    );

    assign unused_wb_load = wb_q.is_load;

`ifdef HAZARD_FORWARD_EN
    assign hazard = match[0] && ex_q.is_load;
`else
    assign hazard = |match;
`endif

    // Redirect outranks a hazard: the instruction in ID is being killed anyway
    always_comb begin
        hif.stop_PC  = 1'b0;
        hif.stop_IF  = 1'b0;
        hif.flush_IF = 1'b0;
        hif.stop_ID  = 1'b0;
        if (hif.ex_redirect) begin
            hif.flush_IF = 1'b1;
            hif.stop_ID  = 1'b1;
        end else if (hazard) begin
            hif.stop_PC  = 1'b1;
            hif.stop_IF  = 1'b1;
            hif.stop_ID  = 1'b1;
        end
    end

    assign stall_evt = hazard && !hif.ex_redirect;

    always_comb begin
        ex_d = SLOT_EMPTY;
        if (!hif.stop_ID) begin
            ex_d.valid   = hif.id_RegWe && (hif.id_RegWr != '0);
            ex_d.rd      = hif.id_RegWr;
            ex_d.is_load = hif.id_is_load;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_evt && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (hif.ex_redirect && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q        <= SLOT_EMPTY;
            mem_q       <= SLOT_EMPTY;
            wb_q        <= SLOT_EMPTY;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= ex_q;
            wb_q        <= mem_q;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hif.stall_cnt = stall_cnt_q;
    assign hif.flush_cnt = flush_cnt_q;

endmodule
